imem_boot_loader: RTL and testbench

Front-end stage ahead of the processor core: accepts a program as a stream of 32-bit instruction words, writes them into instruction memory from address 0, then releases the core by asserting `cpu_run`. It holds `cpu_run` until the core raises `halt`, and reports completion, word count and run-cycle count. The core must not fetch while `cpu_run` is low; this block is the only instruction-memory writer.

---
 rtl/imem_boot_loader.sv | 110 +++++++++++
 tb/tb_imem_boot_loader.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory from address 0, then
// enables the core until it halts, tracking word count and run-cycle count.
module imem_boot_loader #(
   parameter int unsigned ADDR_W    = 10,
   parameter int unsigned MAX_WORDS = 1024
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_run,
   input  logic              halt,
   output logic              done,
   output logic              err_overflow,
   output logic [ADDR_W:0]   word_count,
   output logic [31:0]       run_cycles
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

   // COMMIT is a one-cycle gap so the last write lands before the core is released
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_COMMIT,
      S_RUN,
      S_HALTED,
      S_ERROR
   } state_t;

   state_t           state;
   logic             accept;
   logic [CNT_W-1:0] next_count;

   assign accept     = in_valid & in_ready;
   assign next_count = word_count + CNT_W'(1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         in_ready     <= 1'b0;
         im_we        <= 1'b0;
         im_addr      <= '0;
         im_wdata     <= '0;
         cpu_run      <= 1'b0;
         done         <= 1'b0;
         err_overflow <= 1'b0;
         word_count   <= '0;
         run_cycles   <= '0;
      end else begin
         im_we <= 1'b0;
         case (state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  state      <= S_LOAD;
                  in_ready   <= 1'b1;
                  word_count <= '0;
                  run_cycles <= '0;
                  done       <= 1'b0;
               end
            end
            S_LOAD: begin
               if (accept) begin
                  im_we      <= 1'b1;
                  im_addr    <= word_count[ADDR_W-1:0];
                  im_wdata   <= in_data;
                  word_count <= next_count;
                  if (in_last) begin
                     state    <= S_COMMIT;
                     in_ready <= 1'b0;
                  end else if (next_count == MAX_CNT) begin
                     state        <= S_ERROR;
                     in_ready     <= 1'b0;
                     err_overflow <= 1'b1;
                  end
               end
            end
            S_COMMIT: begin
               state   <= S_RUN;
               cpu_run <= 1'b1;
            end
            S_RUN: begin
               // The halt cycle itself is still counted as a run cycle
               if (run_cycles != '1) begin
                  run_cycles <= run_cycles + 32'd1;
               end
               if (halt) begin
                  state   <= S_HALTED;
                  cpu_run <= 1'b0;
                  done    <= 1'b1;
               end
            end
            S_ERROR: begin
               state <= S_ERROR;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: table-driven cycle vectors plus hand sequences,
// with a write scoreboard fed by the stimulus and drained by im_we beats.
module tb_imem_boot_loader;

   localparam int unsigned ADDR_W    = 3;
   localparam int unsigned MAX_WORDS = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [31:0]       in_data = '0;
   logic              in_last = 1'b0;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_run;
   logic              halt = 1'b0;
   logic              done;
   logic              err_overflow;
   logic [ADDR_W:0]   word_count;
   logic [31:0]       run_cycles;

   imem_boot_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .im_we        (im_we),
      .im_addr      (im_addr),
      .im_wdata     (im_wdata),
      .cpu_run      (cpu_run),
      .halt         (halt),
      .done         (done),
      .err_overflow (err_overflow),
      .word_count   (word_count),
      .run_cycles   (run_cycles)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic              addr_ok;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   typedef struct {
      logic        start;
      logic        valid;
      logic [31:0] data;
      logic        last;
      logic        halt;
      logic        acc;
      logic        exp_ready;
      logic        exp_run;
      logic        exp_done;
      logic [3:0]  exp_wc;
      logic [31:0] exp_cyc;
   } vec_t;

   wr_t  exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // inputs change on negedge; outputs are sampled on the following negedge
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d);
      wr_t w;
      w.addr_ok = 1'b1;
      w.addr    = a;
      w.data    = d;
      exp_q.push_back(w);
   endtask

   task automatic beat(input logic [31:0] d, input logic last, input logic acc,
                       input logic [ADDR_W-1:0] a);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      if (acc) push_wr(a, d);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_in_ready"}, in_ready, 0);
      chk({tag, "_im_we"}, im_we, 0);
      chk({tag, "_cpu_run"}, cpu_run, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err_overflow, 0);
      chk({tag, "_wc"}, word_count, 0);
      chk({tag, "_cyc"}, run_cycles, 0);
      chk({tag, "_addr"}, im_addr, 0);
      chk({tag, "_wdata"}, im_wdata, 0);
   endtask

   // scoreboard drain: every write beat must match the oldest expected write
   always @(negedge clk) begin
      if (im_we) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr %0d data 0x%0h expected no write at %0t",
                     im_addr, im_wdata, $time);
         end else begin
            wr_t w;
            w = exp_q.pop_front();
            chk("wr_addr", im_addr, w.addr);
            chk("wr_data", im_wdata, w.data);
         end
      end
   end

   initial begin
      vec_t vecs[9];
      int   n;

      // reset then idle with stray in_valid pulses
      tick();
      tick();
      chk_reset_vals("rst");
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_valid = i[0];
         in_data  = 32'hDEAD_0000 + i;
         tick();
         chk("idle_in_ready", in_ready, 0);
         chk("idle_im_we", im_we, 0);
      end
      in_valid = 1'b0;

      // back-to-back four-word load, run, halt, repeated halt
      //           start valid data        last halt acc rdy run done wc cyc
      vecs[0] = '{1'b1, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 32'd0};
      vecs[1] = '{1'b0, 1'b1, 32'h11,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'd0};
      vecs[2] = '{1'b0, 1'b1, 32'h22,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'd0};
      vecs[3] = '{1'b0, 1'b1, 32'h33,     1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'd0};
      vecs[4] = '{1'b0, 1'b1, 32'h44,     1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd4, 32'd0};
      vecs[5] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 32'd0};
      vecs[6] = '{1'b0, 1'b1, 32'h99,     1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd4, 32'd1};
      vecs[7] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'd2};
      vecs[8] = '{1'b0, 1'b0, 32'h0,      1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 32'd2};
      n = 0;
      for (int i = 0; i < 9; i++) begin
         start    = vecs[i].start;
         in_valid = vecs[i].valid;
         in_data  = vecs[i].data;
         in_last  = vecs[i].last;
         halt     = vecs[i].halt;
         if (vecs[i].acc) begin
            push_wr(ADDR_W'(n), vecs[i].data);
            n++;
         end
         tick();
         chk($sformatf("v%0d_in_ready", i), in_ready, vecs[i].exp_ready);
         chk($sformatf("v%0d_cpu_run", i), cpu_run, vecs[i].exp_run);
         chk($sformatf("v%0d_done", i), done, vecs[i].exp_done);
         chk($sformatf("v%0d_wc", i), word_count, vecs[i].exp_wc);
         chk($sformatf("v%0d_cyc", i), run_cycles, vecs[i].exp_cyc);
      end
      start = 1'b0; in_valid = 1'b0; in_last = 1'b0; halt = 1'b0;

      // gapped load of five words, halt sampled ten cycles after cpu_run
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("gap_done_clr", done, 0);
      for (int i = 0; i < 5; i++) begin
         beat(32'h100 + i, i == 4, 1'b1, ADDR_W'(i));
         tick();
      end
      n = 0;
      while (!cpu_run && n < 10) begin
         tick();
         n++;
      end
      chk("gap_run_latency", n, 0);
      chk("gap_cpu_run", cpu_run, 1);
      chk("gap_wc", word_count, 5);
      for (int i = 0; i < 9; i++) tick();
      halt = 1'b1;
      tick();
      chk("gap_halt_run", cpu_run, 0);
      chk("gap_halt_done", done, 1);
      chk("gap_halt_cyc", run_cycles, 10);
      tick();
      halt = 1'b0;
      chk("gap_rehalt_cyc", run_cycles, 10);
      chk("gap_rehalt_done", done, 1);

      // reload one-word program from HALTED
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("one_done_clr", done, 0);
      chk("one_cyc_clr", run_cycles, 0);
      chk("one_wc_clr", word_count, 0);
      beat(32'hAAAA_5555, 1'b1, 1'b1, 3'd0);
      chk("one_wc", word_count, 1);
      tick();
      chk("one_cpu_run", cpu_run, 1);

      // reset mid-run, then mid-load, then reload
      rst_n = 1'b0;
      tick();
      chk_reset_vals("rrun");
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 3; i++) beat(32'h200 + i, 1'b0, 1'b1, ADDR_W'(i));
      chk("mid_wc", word_count, 3);
      rst_n = 1'b0;
      tick();
      chk_reset_vals("rload");
      rst_n = 1'b1;
      start = 1'b1;
      tick();
      start = 1'b0;
      beat(32'h55, 1'b1, 1'b1, 3'd0);
      chk("reload_wc", word_count, 1);
      tick();
      chk("reload_run", cpu_run, 1);
      halt = 1'b1;
      tick();
      halt = 1'b0;

      // overflow: nine words without in_last at capacity eight
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 9; i++) begin
         beat(32'h300 + i, 1'b0, i < 8, ADDR_W'(i));
      end
      chk("ovf_err", err_overflow, 1);
      chk("ovf_in_ready", in_ready, 0);
      chk("ovf_wc", word_count, 8);
      chk("ovf_cpu_run", cpu_run, 0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("ovf_start_ready", in_ready, 0);
      chk("ovf_start_err", err_overflow, 1);
      chk("ovf_start_wc", word_count, 8);
      rst_n = 1'b0;
      tick();
      chk_reset_vals("rerr");
      rst_n = 1'b1;
      tick();

      chk("sb_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
